router_sync_n: RTL and testbench

ROUTER_SYNC_N -- requirements
Module: router_sync_n

---
 rtl/router_sync_n_if.sv | 31 +++
 rtl/router_sync_n.sv | 97 +++++++++
 tb/tb_router_sync_n.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/router_sync_n_if.sv
// Router synchronizer bus: header/address strobe, FIFO status and per-port
// handshakes that pass between the router FSM/FIFOs and router_sync_n.
//   master : drives detect_add, datain, write_enb_reg, full, empty, read_enb
//   slave  : drives write_enb, fifo_full, vld_out, soft_reset, addr_valid, addr_err
interface router_sync_n_if #(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned ADDR_W    = 2
);
  logic                 detect_add;
  logic [ADDR_W-1:0]    datain;
  logic                 write_enb_reg;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] read_enb;
  logic [NUM_PORTS-1:0] write_enb;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] vld_out;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 addr_valid;
  logic                 addr_err;

  modport master (
    output detect_add, datain, write_enb_reg, full, empty, read_enb,
    input  write_enb, fifo_full, vld_out, soft_reset, addr_valid, addr_err
  );

  modport slave (
    input  detect_add, datain, write_enb_reg, full, empty, read_enb,
    output write_enb, fifo_full, vld_out, soft_reset, addr_valid, addr_err
  );
endinterface

// File: rtl/router_sync_n.sv
// Router synchronizer: latches the destination address of each packet header,
// steers FIFO writes and the addressed full flag, exposes per-port valid, and
// flushes any output FIFO whose data sits unread for TIMEOUT consecutive cycles.
// Ports:
//   clk    : single clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : router_sync_n_if slave (address, write steering, status, soft resets)
module router_sync_n #(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned TIMEOUT   = 30
) (
  input  logic            clk,
  input  logic            resetn,
  router_sync_n_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  // One extra bit so NUM_PORTS itself is representable even when it equals 2**ADDR_W.
  localparam int unsigned CMP_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0]    addr_reg;
  logic                 addr_valid_q;
  logic                 addr_err_q;
  logic [NUM_PORTS-1:0] soft_reset_q;
  logic [CNT_W-1:0]     stall_cnt [NUM_PORTS];

  logic                 in_range_c;
  logic [NUM_PORTS-1:0] vld_c;
  logic [NUM_PORTS-1:0] write_enb_c;
  logic                 fifo_full_c;

  assign in_range_c = {1'b0, bus.datain} < CMP_W'(NUM_PORTS);
  assign vld_c      = ~bus.empty;

  // Header address capture; addr_err is a single-cycle pulse per bad header.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_reg     <= '0;
      addr_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      addr_err_q <= 1'b0;
      if (bus.detect_add) begin
        addr_reg     <= bus.datain;
        addr_valid_q <= in_range_c;
        addr_err_q   <= ~in_range_c;
      end
    end
  end

  // Write steering and addressed full flag; an invalid address selects nothing,
  // so fifo_full stays low and misaddressed packets drain.
  always_comb begin
    write_enb_c = '0;
    fifo_full_c = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (addr_valid_q && (addr_reg == ADDR_W'(i))) begin
        write_enb_c[i] = bus.write_enb_reg;
        fifo_full_c    = bus.full[i];
      end
    end
  end

  // Per-port stall timers; wrapping to zero on the TIMEOUT-th stalled edge
  // both fires the flush pulse and bounds the counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        stall_cnt[i] <= '0;
      end
      soft_reset_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (!vld_c[i] || bus.read_enb[i]) begin
          stall_cnt[i]    <= '0;
          soft_reset_q[i] <= 1'b0;
        end else if (stall_cnt[i] == CNT_LAST) begin
          stall_cnt[i]    <= '0;
          soft_reset_q[i] <= 1'b1;
        end else begin
          stall_cnt[i]    <= stall_cnt[i] + CNT_W'(1);
          soft_reset_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.write_enb  = write_enb_c;
  assign bus.fifo_full  = fifo_full_c;
  assign bus.vld_out    = vld_c;
  assign bus.soft_reset = soft_reset_q;
  assign bus.addr_valid = addr_valid_q;
  assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_router_sync_n.sv
// Bench for router_sync_n: stimulus pushes time-stamped expectations into a
// scoreboard queue; a negedge monitor pops and compares them against the DUTs.
// dut3 uses the default parameters, dut4 is the NUM_PORTS=4/TIMEOUT=5 variant.
module tb_router_sync_n;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  router_sync_n_if #(.NUM_PORTS(3), .ADDR_W(2)) b3 ();
  router_sync_n_if #(.NUM_PORTS(4), .ADDR_W(2)) b4 ();

  router_sync_n #(.NUM_PORTS(3), .ADDR_W(2), .TIMEOUT(30)) dut3 (
    .clk(clk), .resetn(resetn), .bus(b3)
  );
  router_sync_n #(.NUM_PORTS(4), .ADDR_W(2), .TIMEOUT(5)) dut4 (
    .clk(clk), .resetn(resetn), .bus(b4)
  );

  typedef enum {K_WE, K_FF, K_AV, K_AE, K_SR, K_VLD, K4_WE, K4_AE, K4_SR} kind_e;
  typedef struct {
    int unsigned cyc;
    kind_e       kind;
    logic [7:0]  val;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_total = 0;
  int unsigned n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] observe(kind_e k);
    logic [7:0] v;
    v = '0;
    case (k)
      K_WE:    v = 8'(b3.write_enb);
      K_FF:    v = 8'(b3.fifo_full);
      K_AV:    v = 8'(b3.addr_valid);
      K_AE:    v = 8'(b3.addr_err);
      K_SR:    v = 8'(b3.soft_reset);
      K_VLD:   v = 8'(b3.vld_out);
      K4_WE:   v = 8'(b4.write_enb);
      K4_AE:   v = 8'(b4.addr_err);
      K4_SR:   v = 8'(b4.soft_reset);
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic chk(kind_e k, logic [7:0] v);
    sb.push_back('{cyc: cyc, kind: k, val: v});
  endtask

  task automatic tally(bit ok, string what);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s cyc=%0d", what, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: everything stamped for the current cycle is compared at negedge.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [7:0] got;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      got = observe(e.kind);
      n_total++;
      if (e.cyc == cyc && got === e.val) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0h want=%0h", e.kind.name(), e.cyc, got, e.val);
    end
  end

  initial begin
    b3.detect_add = 0; b3.datain = '0; b3.write_enb_reg = 0;
    b3.full = '0; b3.empty = '1; b3.read_enb = '0;
    b4.detect_add = 0; b4.datain = '0; b4.write_enb_reg = 0;
    b4.full = '0; b4.empty = '1; b4.read_enb = '0;

    // Reset: everything cleared, vld_out still follows empty.
    resetn = 0;
    b3.empty = 3'b010; b3.write_enb_reg = 1; b3.full = '1;
    step;
    chk(K_AV, 0); chk(K_AE, 0); chk(K_SR, 0); chk(K_WE, 0); chk(K_FF, 0);
    chk(K_VLD, 8'h05); chk(K4_SR, 0); chk(K4_AE, 0);
    #1;
    tally(b3.vld_out === 3'b101, "reset vld_out");
    tally(b3.soft_reset === 3'b000, "reset soft_reset");
    tally(b3.addr_valid === 1'b0, "reset addr_valid");
    step;
    resetn = 1; b3.empty = '1; b3.write_enb_reg = 0; b3.full = '0;
    chk(K_VLD, 8'h00);

    // Latch address 2, then write with FIFO 2 full.
    step; b3.detect_add = 1; b3.datain = 2'b10;
    chk(K_AV, 0); chk(K_WE, 0);
    step; b3.detect_add = 0; b3.write_enb_reg = 1; b3.full = 3'b100;
    chk(K_WE, 8'h04); chk(K_FF, 1); chk(K_AV, 1); chk(K_AE, 0);
    #1;
    tally(b3.write_enb === 3'b100, "addr2 write_enb");
    tally(b3.fifo_full === 1'b1, "addr2 fifo_full");
    tally(b3.addr_valid === 1'b1, "addr2 addr_valid");

    // Header and write together: old address still steers this cycle.
    step; b3.detect_add = 1; b3.datain = 2'b00; b3.full = 3'b001;
    chk(K_WE, 8'h04); chk(K_FF, 0);
    step; b3.detect_add = 0;
    chk(K_WE, 8'h01); chk(K_FF, 1); chk(K_AV, 1);

    // Out-of-range address 3.
    step; b3.detect_add = 1; b3.datain = 2'b11; b3.write_enb_reg = 0;
    chk(K_WE, 0);
    step; b3.detect_add = 0; b3.write_enb_reg = 1; b3.full = 3'b111;
    chk(K_AE, 1); chk(K_AV, 0); chk(K_WE, 0); chk(K_FF, 0);
    #1;
    tally(b3.addr_err === 1'b1, "addr3 addr_err");
    tally(b3.addr_valid === 1'b0, "addr3 addr_valid");
    tally(b3.write_enb === 3'b000, "addr3 write_enb");
    step;
    chk(K_AE, 0); chk(K_AV, 0); chk(K_WE, 0);

    // Address 1 write.
    step; b3.detect_add = 1; b3.datain = 2'b01; b3.write_enb_reg = 0; b3.full = 3'b000;
    step; b3.detect_add = 0; b3.write_enb_reg = 1; b3.full = 3'b010;
    chk(K_WE, 8'h02); chk(K_FF, 1); chk(K_AV, 1); chk(K_AE, 0);
    step; b3.write_enb_reg = 0; b3.full = '0;
    chk(K_WE, 0); chk(K_FF, 0);

    // Port 1 stalls: pulses after edges 30 and 60.
    step; b3.empty = 3'b101; b3.read_enb = '0;
    chk(K_VLD, 8'h02); chk(K_SR, 0);
    for (int k = 1; k <= 65; k++) begin
      step;
      chk(K_SR, (k == 30 || k == 60) ? 8'h02 : 8'h00);
    end
    b3.empty = '1;
    step; chk(K_SR, 0);

    // Read in the cycle the counter holds 29: no pulse, count restarts.
    step; b3.empty = 3'b101;
    chk(K_SR, 0);
    for (int k = 1; k <= 62; k++) begin
      step;
      b3.read_enb = (k == 29) ? 3'b010 : 3'b000;
      chk(K_SR, (k == 60) ? 8'h02 : 8'h00);
    end
    b3.empty = '1; b3.read_enb = '0;
    step; chk(K_SR, 0);

    // Ports 0 and 2 stall together.
    step; b3.empty = 3'b010;
    chk(K_SR, 0);
    for (int k = 1; k <= 32; k++) begin
      step;
      chk(K_SR, (k == 30) ? 8'h05 : 8'h00);
    end
    b3.empty = '1;
    step; chk(K_SR, 0);

    // Same stall with reset pulsed at cycle 15: next pulse 30 edges after release.
    step; b3.empty = 3'b010;
    chk(K_SR, 0);
    for (int k = 1; k <= 48; k++) begin
      step;
      if (k == 15) resetn = 0;
      if (k == 16) resetn = 1;
      chk(K_SR, (k == 46) ? 8'h05 : 8'h00);
      if (k == 15) chk(K_AV, 0);
    end
    b3.empty = '1;
    step; chk(K_SR, 0);

    // Four-port variant: one-hot writes, no addr_err on any address.
    for (int a = 0; a < 4; a++) begin
      step; b4.detect_add = 1; b4.datain = 2'(a); b4.write_enb_reg = 0;
      step; b4.detect_add = 0; b4.write_enb_reg = 1;
      chk(K4_WE, 8'(1 << a)); chk(K4_AE, 0);
      #1;
      tally(b4.write_enb === 4'(1 << a), "p4 write_enb");
      tally(b4.addr_err === 1'b0, "p4 addr_err");
    end
    step; b4.write_enb_reg = 0;
    chk(K4_WE, 0);

    // Four-port variant: port 3 stall pulses after edges 5 and 10.
    step; b4.empty = 4'b0111;
    chk(K4_SR, 0);
    for (int k = 1; k <= 11; k++) begin
      step;
      chk(K4_SR, (k == 5 || k == 10) ? 8'h08 : 8'h00);
    end
    b4.empty = '1;
    step; chk(K4_SR, 0);

    repeat (3) step;
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_total++;
      $display("FAIL %s cyc=%0d never compared want=%0h", e.kind.name(), e.cyc, e.val);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
